muldiv_hilo_unit: RTL and testbench
===================================

// Module: muldiv_hilo_unit
// PURPOSE
//  Iterative multiply/divide unit with architectural HI/LO registers, sitting in EX.
//  Consumes the EX control decode flags (is_mult/is_div/is_signed/is_mfhi/is_mflo/
//  is_mthi/is_mtlo) and operands. Runs MULT/MULTU/DIV/DIVU over WIDTH+1 cycles.
//  Drives a stall back to the hazard logic while a result is pending.
// PARAMETERS
//  WIDTH   32               operand width; HI/LO are each WIDTH bits
//  CNT_W   $clog2(WIDTH)+1  iteration counter width (derived, do not override)
// PORTS
//  clk         in   1      rising-edge clock
//  rst_n       in   1      synchronous reset, active low
//  ex_valid    in   1      EX instruction valid and not being flushed this cycle
//  is_mult     in   1      MULT/MULTU in EX
//  is_div      in   1      DIV/DIVU in EX
//  is_signed   in   1      1 = signed variant (MULT/DIV)
//  is_mfhi     in   1      MFHI in EX
//  is_mflo     in   1      MFLO in EX
//  is_mthi     in   1      MTHI in EX
//  is_mtlo     in   1      MTLO in EX
//  rs_data     in   WIDTH  forwarded rs (multiplicand/dividend, MTHI/MTLO source)
//  rt_data     in   WIDTH  forwarded rt (multiplier/divisor)
//  hilo_rdata  out  WIDTH  HI when is_mfhi else LO; combinational
//  busy        out  1      state != IDLE
//  stall       out  1      ex_valid & busy & (any of the six is_* flags)
//  done        out  1      one-cycle pulse on the cycle after HI/LO are written
// BEHAVIOUR
//  Reset: state=IDLE, hi=lo=0, counter=0, done=0, all internal operand regs=0.
//  Reset mid-operation aborts the operation; HI/LO are cleared, not written.
//  FSM: IDLE -> MUL | DIV -> FIX -> IDLE.
//  IDLE accept (edge E0): ex_valid & ~busy & is_mult -> MUL; else & is_div -> DIV.
//   is_mult has priority if both flags are set. On accept, latch |rs| and |rt|
//   (magnitudes only if is_signed), neg_res = signed & (rs[MSB]^rt[MSB]),
//   neg_rem = signed & rs[MSB], div0 = (rt==0). Counter = WIDTH-1.
//  MUL: radix-2 shift-add, one bit per edge; 2*WIDTH-bit accumulator.
//  DIV: restoring, one quotient bit per edge (WIDTH+1-bit partial remainder).
//  After WIDTH iterations (E1..E_WIDTH), counter==0 -> FIX.
//  FIX (edge E_WIDTH+1): apply two's-complement fixups and write HI/LO -> IDLE.
//   MUL: {hi,lo} = neg_res ? -prod : prod.
//   DIV: lo = neg_res ? -quot : quot; hi = neg_rem ? -rem : rem.
//  done=1 for the cycle following E_WIDTH+1. busy is high for WIDTH+1 cycles after E0.
//  Latency: an MFHI/MFLO issued directly behind MULT stalls WIDTH+1 cycles, then
//   reads the new value.
//  Div by zero: lo=all ones, hi=rs_data as latched (original sign); no sign fixup.
//  Signed overflow (-2^(WIDTH-1) / -1): lo=32'h8000_0000, hi=0 (natural wrap).
//  MTHI/MTLO: when ex_valid & ~busy, write hi/lo from rs_data on the edge.
//   Stalled while busy.
//  MFHI/MFLO while IDLE: no stall; hilo_rdata shows current hi/lo.
//   A same-cycle MTHI/MTLO is impossible (one instruction per EX).
//  Flush: ex_valid=0 blocks a new accept only. An in-flight operation is never
//   cancelled; it completes and writes HI/LO.
//  Overlapping start while busy: not accepted; stall held until IDLE.
//   Accepted on the first IDLE cycle.
//  Operands are frozen at accept. rs_data/rt_data changes during MUL/DIV are ignored.
// STRUCTURE
//  Package muldiv_pkg: state encoding (IDLE,MUL,DIV,FIX), WIDTH default,
//   funct codes 6'h18..6'h1B, 6'h10..6'h13 shared with the EX decoder.
//  Sub-module muldiv_iter_step: combinational single step. Inputs: mode,
//   accumulator/remainder, operand. Outputs: next accumulator/remainder and quotient bit.
//  Top holds the FSM, counter, operand/sign registers, fixup and HI/LO.
// TESTING
//  MULT 0xFFFFFFFE * 0x00000003 (signed) -> hi=0xFFFFFFFF lo=0xFFFFFFFA
//   after 33 busy cycles; done pulses once.
//  MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
//  DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//   DIVU 100/7 -> lo=14, hi=2.
//   DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
//  DIVU 5/0 -> lo=0xFFFFFFFF, hi=5.
//   MFLO issued at E0+1 -> stall=1 for 33 cycles, then hilo_rdata=0xFFFFFFFF.
//  MTHI 0x1234 while idle -> hi=0x1234 next cycle.
//   MTLO while busy -> stalled; lo written only after done.
//  rst_n=0 at iteration 10 of DIV -> state IDLE, hi=lo=0, busy=0 next cycle.
//   A following MULT 3*4 gives lo=12.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit and the EX decoder.
package muldiv_pkg;
  localparam int MULDIV_WIDTH = 32;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_e;
  typedef enum logic {STEP_MUL, STEP_DIV} step_mode_e;

  // SPECIAL-opcode funct codes handled by this unit
  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;
endpackage

// File: rtl/muldiv_iter_step.sv
// One iteration of the unsigned multiply (shift-add) or divide (restoring).
// Accumulator layout: MUL {partial_hi, multiplier_rest}; DIV {remainder, dividend_rest/quotient}.
module muldiv_iter_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  step_mode_e         mode_i,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   operand_i,
  output logic [2*WIDTH-1:0] acc_o,
  output logic               q_bit_o
);
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] rem_sub;
  logic             ge;

  always_comb begin
    addend  = acc_i[0] ? operand_i : {WIDTH{1'b0}};
    sum     = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    shifted = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
    ge      = shifted >= {1'b0, operand_i};
    // remainder after subtract is below the divisor, so the low WIDTH bits suffice
    rem_sub = shifted[WIDTH-1:0] - operand_i;
    q_bit_o = 1'b0;
    acc_o   = {sum, acc_i[WIDTH-1:1]};
    if (mode_i == STEP_DIV) begin
      q_bit_o = ge;
      acc_o   = {(ge ? rem_sub : shifted[WIDTH-1:0]), acc_i[WIDTH-2:0], ge};
    end
  end
endmodule

// File: rtl/muldiv_hilo_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with architectural HI/LO, stalling EX while busy.
// Operands are reduced to magnitudes at accept; signs are re-applied in FIX.
module muldiv_hilo_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic             is_mult,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic             is_mfhi,
  input  logic             is_mflo,
  input  logic             is_mthi,
  input  logic             is_mtlo,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic [WIDTH-1:0] hilo_rdata,
  output logic             busy,
  output logic             stall,
  output logic             done
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opa_q, opa_d, opb_q, opb_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
  logic               div0_q, div0_d, op_div_q, op_div_d, done_q, done_d;

  logic [WIDTH-1:0]   rs_mag, rt_mag, step_operand;
  logic [2*WIDTH-1:0] step_acc, prod_fix;
  logic               step_q;
  step_mode_e         step_mode;

  assign busy       = (state_q != IDLE);
  assign stall      = ex_valid & busy & (is_mult | is_div | is_mfhi | is_mflo | is_mthi | is_mtlo);
  assign done       = done_q;
  assign hilo_rdata = is_mfhi ? hi_q : lo_q;

  assign rs_mag       = (is_signed & rs_data[WIDTH-1]) ? -rs_data : rs_data;
  assign rt_mag       = (is_signed & rt_data[WIDTH-1]) ? -rt_data : rt_data;
  assign step_mode    = (state_q == DIV) ? STEP_DIV : STEP_MUL;
  assign step_operand = (state_q == DIV) ? opb_q : opa_q;
  assign prod_fix     = neg_res_q ? -acc_q : acc_q;

  muldiv_iter_step #(.WIDTH(WIDTH)) u_step (
    .mode_i    (step_mode),
    .acc_i     (acc_q),
    .operand_i (step_operand),
    .acc_o     (step_acc),
    .q_bit_o   (step_q)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    op_div_d  = op_div_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (ex_valid && (is_mult || is_div)) begin
          opa_d     = rs_mag;
          opb_d     = rt_mag;
          neg_res_d = is_signed & (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
          neg_rem_d = is_signed & rs_data[WIDTH-1];
          div0_d    = (rt_data == '0);
          op_div_d  = ~is_mult;
          acc_d     = is_mult ? {{WIDTH{1'b0}}, rt_mag} : {{WIDTH{1'b0}}, rs_mag};
          cnt_d     = CNT_W'(WIDTH - 1);
          state_d   = is_mult ? MUL : DIV;
        end else if (ex_valid) begin
          if (is_mthi) hi_d = rs_data;
          if (is_mtlo) lo_d = rs_data;
        end
      end
      MUL, DIV: begin
        acc_d = (state_q == DIV) ? {step_acc[2*WIDTH-1:1], step_q} : step_acc;
        if (cnt_q == '0) state_d = FIX;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      FIX: begin
        done_d  = 1'b1;
        state_d = IDLE;
        if (!op_div_q) begin
          {hi_d, lo_d} = prod_fix;
        end else if (div0_q) begin
          lo_d = '1;
          hi_d = neg_rem_q ? -opa_q : opa_q;
        end else begin
          lo_d = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
          hi_d = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      op_div_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      op_div_q  <= op_div_d;
      done_q    <= done_d;
    end
  end
endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Directed bench: reads of HI/LO are scoreboarded; a monitor compares on every unstalled read.
module tb_muldiv_hilo_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, is_mult, is_div, is_signed;
  logic        is_mfhi, is_mflo, is_mthi, is_mtlo;
  logic [31:0] rs_data, rt_data;
  logic [31:0] hilo_rdata;
  logic        busy, stall, done;
  logic        rd_strobe;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;
  exp_t exp_q[$];

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  muldiv_hilo_unit dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid),
    .is_mult(is_mult), .is_div(is_div), .is_signed(is_signed),
    .is_mfhi(is_mfhi), .is_mflo(is_mflo), .is_mthi(is_mthi), .is_mtlo(is_mtlo),
    .rs_data(rs_data), .rt_data(rt_data),
    .hilo_rdata(hilo_rdata), .busy(busy), .stall(stall), .done(done)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
      $display("ok   %s: got 0x%08h", nm, act);
    end else begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: an unstalled read in EX is the unit presenting an output
  always @(negedge clk) begin
    if (rd_strobe && !stall) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_read: got 0x%08h, expected no read", hilo_rdata);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check(e.name, hilo_rdata, e.val);
      end
    end
  end

  task automatic clear_inputs();
    ex_valid = 0; is_mult = 0; is_div = 0; is_signed = 0;
    is_mfhi = 0; is_mflo = 0; is_mthi = 0; is_mtlo = 0;
    rd_strobe = 0;
  endtask

  // Returns just after the accept edge E0
  task automatic issue(input logic m, input logic d, input logic s,
                       input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    ex_valid = 1; is_mult = m; is_div = d; is_signed = s; rs_data = a; rt_data = b;
    @(posedge clk); #1;
    clear_inputs();
  endtask

  task automatic wait_done(input string nm);
    int bc = 0;
    int dc = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) dc++;
      if (busy) bc++;
      else break;
    end
    @(negedge clk);
    if (done) dc++;
    check({nm, "_busy_cycles"}, bc, 33);
    check({nm, "_done_pulses"}, dc, 1);
  endtask

  task automatic rd(input logic hi_sel, input logic [31:0] exp, input string nm);
    exp_t e;
    @(posedge clk); #1;
    ex_valid = 1; is_mfhi = hi_sel; is_mflo = !hi_sel;
    e.name = nm; e.val = exp;
    exp_q.push_back(e);
    rd_strobe = 1;
    @(negedge clk); #1;
    clear_inputs();
  endtask

  // Hold the current EX instruction and count cycles it is stalled
  task automatic count_stall(input string nm);
    int sc = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (stall) sc++;
      else break;
    end
    check({nm, "_stall_cycles"}, sc, 33);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    rs_data = 0; rt_data = 0;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    check("reset_busy", {31'b0, busy}, 0);
    check("reset_done", {31'b0, done}, 0);
    rd(1, 32'h0, "reset_hi");
    rd(0, 32'h0, "reset_lo");

    issue(1, 0, 1, 32'hFFFF_FFFE, 32'h0000_0003);
    wait_done("mult");
    rd(1, 32'hFFFF_FFFF, "mult_hi");
    rd(0, 32'hFFFF_FFFA, "mult_lo");

    issue(1, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("multu");
    rd(1, 32'hFFFF_FFFE, "multu_hi");
    rd(0, 32'h0000_0001, "multu_lo");

    issue(0, 1, 1, 32'hFFFF_FFF9, 32'h0000_0002);
    wait_done("div_neg");
    rd(0, 32'hFFFF_FFFD, "div_neg_lo");
    rd(1, 32'hFFFF_FFFF, "div_neg_hi");

    issue(0, 1, 0, 32'd100, 32'd7);
    wait_done("divu");
    rd(0, 32'd14, "divu_lo");
    rd(1, 32'd2, "divu_hi");

    issue(0, 1, 1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_ovf");
    rd(0, 32'h8000_0000, "div_ovf_lo");
    rd(1, 32'h0, "div_ovf_hi");

    // DIVU 5/0 with MFLO directly behind it
    issue(0, 1, 0, 32'd5, 32'd0);
    begin
      exp_t e;
      e.name = "div0_mflo_after_stall"; e.val = 32'hFFFF_FFFF;
      exp_q.push_back(e);
    end
    ex_valid = 1; is_mflo = 1; rd_strobe = 1;
    count_stall("div0_mflo");
    @(posedge clk); #1;
    clear_inputs();
    rd(1, 32'd5, "div0_hi");

    // MTHI while idle
    @(posedge clk); #1;
    ex_valid = 1; is_mthi = 1; rs_data = 32'h0000_1234;
    @(posedge clk); #1;
    clear_inputs();
    rd(1, 32'h0000_1234, "mthi_hi");

    // MTLO behind MULTU 3*4; its rs also changes the frozen multiplicand
    issue(1, 0, 0, 32'd3, 32'd4);
    ex_valid = 1; is_mtlo = 1; rs_data = 32'h0000_ABCD;
    count_stall("mtlo_busy");
    @(posedge clk); #1;
    clear_inputs();
    rd(0, 32'h0000_ABCD, "mtlo_lo");
    rd(1, 32'h0, "mtlo_mult_hi");

    // flushed MULT must not start
    @(posedge clk); #1;
    ex_valid = 0; is_mult = 1; rs_data = 32'd5; rt_data = 32'd5;
    @(posedge clk);
    @(negedge clk);
    check("flush_busy", {31'b0, busy}, 0);
    #1 clear_inputs();

    // DIVU held behind MULTU 2*3 is accepted on the first idle cycle
    issue(1, 0, 0, 32'd2, 32'd3);
    ex_valid = 1; is_div = 1; rs_data = 32'd9; rt_data = 32'd2;
    count_stall("overlap");
    @(posedge clk); #1;
    clear_inputs();
    wait_done("overlap_div");
    rd(0, 32'd4, "overlap_lo");
    rd(1, 32'd1, "overlap_hi");

    // reset part-way through a DIV
    issue(0, 1, 0, 32'd100, 32'd7);
    repeat (10) @(posedge clk);
    #1 rst_n = 0;
    @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    check("midreset_busy", {31'b0, busy}, 0);
    rd(1, 32'h0, "midreset_hi");
    rd(0, 32'h0, "midreset_lo");

    issue(1, 0, 1, 32'd3, 32'd4);
    wait_done("post_reset_mult");
    rd(0, 32'd12, "post_reset_lo");
    rd(1, 32'd0, "post_reset_hi");

    repeat (2) @(posedge clk);
    while (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_total++;
      $display("FAIL %s: read never completed, expected 0x%08h", e.name, e.val);
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
